// File: rtl/fft_pkg.sv
// fft_pkg: constants and types shared by the 32-point FFT front end and its
// stages.
//   FFT_POINTS       : number of points per frame
//   FFT_LOG2         : log2(FFT_POINTS), the width of a point index
//   fft_load_state_t : output-side state of the frame loader
package fft_pkg;

  localparam int FFT_POINTS = 32;
  localparam int FFT_LOG2   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    START = 2'd2,
    BUSY  = 2'd3
  } fft_load_state_t;

endpackage

// File: rtl/fft_input_loader.sv
// fft_input_loader: collects a stream of real samples into 32-word frames in
// natural order and hands each frame to the first FFT stage as parallel words.
// A fill bank takes the next frame while the output bank is held stable for
// the stage, so filling overlaps processing.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   in_data      in   sample word (DATA_WIDTH, two's complement)
//   in_valid     in   in_data is valid this cycle
//   in_sof       in   start of frame, qualified by in_valid (marks sample 0)
//   in_ready     out  a sample is accepted this cycle if in_valid is high
//   stage_start  out  one-cycle start pulse to stage 1
//   stage_finish in   finish pulse from stage 1
//   frame_out    out  output bank; word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   busy         out  frame handed over, finish not yet seen
//   frame_err    out  one-cycle pulse after a start-of-frame cut a frame short
module fft_input_loader
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int INTEGER    = 4,
  parameter int FRACTION   = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic                             in_valid,
  input  logic                             in_sof,
  output logic                             in_ready,
  output logic                             stage_start,
  input  logic                             stage_finish,
  output logic [FFT_POINTS*DATA_WIDTH-1:0] frame_out,
  output logic                             busy,
  output logic                             frame_err
);

  localparam logic [FFT_LOG2-1:0] LAST_IDX = FFT_LOG2'(FFT_POINTS - 1);

  // The Q-format parameters only travel down the stage parameter chain; this
  // consistency guard is their sole use here.
  if (INTEGER + FRACTION != DATA_WIDTH) begin : g_qformat_mismatch
    $error("fft_input_loader: INTEGER + FRACTION must equal DATA_WIDTH");
  end

  fft_load_state_t       state_reg;
  fft_load_state_t       state_next;
  logic [DATA_WIDTH-1:0] fill_mem     [FFT_POINTS];
  logic [DATA_WIDTH-1:0] out_bank_reg [FFT_POINTS];
  logic [FFT_LOG2-1:0]   wr_idx_reg;
  logic [FFT_LOG2-1:0]   wr_ptr;
  logic                  full_reg;
  logic                  frame_err_reg;
  logic                  accept;

  // ---------------------------------------------------------------- fill side
  // A complete frame parks in the fill bank and blocks input until the
  // output side has copied it.
  assign in_ready = ~full_reg & ~reset;
  assign accept   = in_valid & in_ready;

  // A start-of-frame always lands in slot 0, restarting any partial frame.
  assign wr_ptr = in_sof ? '0 : wr_idx_reg;

  always_ff @(posedge clk) begin
    if (accept) begin
      fill_mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx_reg    <= '0;
      full_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= accept & in_sof & (wr_idx_reg != '0);
      if (accept) begin
        // Index wraps to 0 naturally after slot 31.
        wr_idx_reg <= wr_ptr + FFT_LOG2'(1);
        if (wr_ptr == LAST_IDX) begin
          full_reg <= 1'b1;
        end
      end else if (state_reg == XFER) begin
        // No sample can be accepted while full, so this never races a write.
        full_reg <= 1'b0;
      end
    end
  end

  assign frame_err = frame_err_reg;

  // -------------------------------------------------------------- output side
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FFT_POINTS; i++) begin
        out_bank_reg[i] <= '0;
      end
    end else if (state_reg == XFER) begin
      out_bank_reg <= fill_mem;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // stage_start and busy decode the registered state, so both are glitch-free
  // and stage_start lands in the cycle right after the bank copy.
  always_comb begin
    state_next  = state_reg;
    stage_start = 1'b0;
    busy        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (full_reg) begin
          state_next = XFER;
        end
      end
      XFER: begin
        state_next = START;
      end
      START: begin
        stage_start = 1'b1;
        busy        = 1'b1;
        // A stage that finishes immediately is honoured here as well.
        state_next  = stage_finish ? IDLE : BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (stage_finish) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < FFT_POINTS; gi++) begin : g_pack
      assign frame_out[gi*DATA_WIDTH +: DATA_WIDTH] = out_bank_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_fft_input_loader.sv
// Bench for fft_input_loader: directed frame table, hand-written corner
// sequences and a randomized stream, all cross-checked every cycle against a
// queue-based reference model of the loader.
module tb_fft_input_loader;
  import fft_pkg::*;

  localparam int DW = 8;
  localparam int FW = FFT_POINTS * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_sof;
  logic          in_ready;
  logic          stage_start;
  logic          stage_finish;
  logic [FW-1:0] frame_out;
  logic          busy;
  logic          frame_err;

  always #5 clk = ~clk;

  fft_input_loader #(
    .DATA_WIDTH(DW),
    .INTEGER   (4),
    .FRACTION  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .in_ready    (in_ready),
    .stage_start (stage_start),
    .stage_finish(stage_finish),
    .frame_out   (frame_out),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the partial frame is a queue, a completed frame waits in
  // m_frame, and the handover is tracked as copy / start / busy flags.
  bit            m_live = 1'b0;
  logic [DW-1:0] m_cur[$];
  logic [DW-1:0] m_frame [FFT_POINTS];
  bit            m_full, m_xfer, m_start, m_busy, m_err;
  logic [FW-1:0] m_out;

  // Stage responder and event counters.
  bit auto_fin  = 1'b1;
  int fin_delay = 4;
  int fin_cnt   = 0;
  bit fin_force = 1'b0;
  int n_starts  = 0;
  int n_errs    = 0;

  typedef struct {
    int base;
    int pre;
    bit sof0;
    bit gap;
    int fin_dly;
    int exp_w0;
    int exp_w31;
    int exp_errs;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit acc, n_xfer, n_start, n_busy, clr;
    if (reset) begin
      m_live = 1'b1;
      m_cur.delete();
      m_full = 0; m_xfer = 0; m_start = 0; m_busy = 0; m_err = 0;
      m_out = '0;
      return;
    end
    if (!m_live) return;
    acc     = in_valid && !m_full;
    n_xfer  = 0;
    n_start = 0;
    n_busy  = m_busy;
    clr     = 0;
    if (m_xfer) begin
      for (int k = 0; k < FFT_POINTS; k++) m_out[k*DW +: DW] = m_frame[k];
      n_start = 1; n_busy = 1; clr = 1;
    end else if (m_busy) begin
      if (stage_finish) n_busy = 0;
    end else if (m_full) begin
      n_xfer = 1;
    end
    m_err = 0;
    if (acc) begin
      if (in_sof && m_cur.size() != 0) begin
        m_err = 1;
        m_cur.delete();
      end
      m_cur.push_back(in_data);
      if (m_cur.size() == FFT_POINTS) begin
        for (int k = 0; k < FFT_POINTS; k++) m_frame[k] = m_cur[k];
        m_cur.delete();
        m_full = 1;
      end
    end
    if (clr) m_full = 0;
    m_xfer  = n_xfer;
    m_start = n_start;
    m_busy  = n_busy;
  endtask

  // One clock: check outputs mid-cycle, advance the model on the edge, then
  // drive the stage finish line.
  task automatic tick();
    @(negedge clk);
    if (m_live) begin
      chk("in_ready",    FW'(in_ready),    FW'(!m_full && !reset));
      chk("stage_start", FW'(stage_start), FW'(m_start));
      chk("busy",        FW'(busy),        FW'(m_busy));
      chk("frame_err",   FW'(frame_err),   FW'(m_err));
      chk("frame_out",   frame_out,        m_out);
    end
    if (stage_start) n_starts++;
    if (frame_err)   n_errs++;
    @(posedge clk);
    model_step();
    #1;
    stage_finish = fin_force;
    fin_force    = 1'b0;
    if (fin_cnt > 0) begin
      fin_cnt--;
      if (fin_cnt == 0) stage_finish = 1'b1;
    end
    if (auto_fin && stage_start) begin
      if (fin_delay == 0) stage_finish = 1'b1;
      else fin_cnt = fin_delay;
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input bit sof, input bit gap);
    bit acc;
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    do begin
      acc = in_ready;
      tick();
      waited++;
    end while (!acc && waited < 300);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    chk("send_accepted", FW'(acc), FW'(1));
    if (gap) tick();
  endtask

  task automatic wait_start(input int limit);
    int w;
    w = 0;
    while (!stage_start && w < limit) begin
      tick();
      w++;
    end
    chk("start_seen", FW'(stage_start), FW'(1));
  endtask

  task automatic wait_idle(input int limit);
    int w;
    w = 0;
    while (busy && w < limit) begin
      tick();
      w++;
    end
    chk("idle_reached", FW'(busy), FW'(0));
  endtask

  task automatic pulse_finish();
    fin_force = 1'b1;
    tick();
    tick();
  endtask

  task automatic send_frame(input int base, input bit sof0, input bit gap);
    for (int i = 0; i < FFT_POINTS; i++) begin
      send(DW'(base + i), (i == 0) ? sof0 : 1'b0, gap);
    end
  endtask

  initial begin
    int s0, e0, c;
    reset        = 1'b1;
    in_data      = '0;
    in_valid     = 1'b0;
    in_sof       = 1'b0;
    stage_finish = 1'b0;

    //            base pre sof0 gap fin  w0   w31 errs
    vecs[0] = '{  0,   0,  1,   0,  4,    0,  31, 0};
    vecs[1] = '{ 55,  10,  1,   0,  2,   55,  86, 1};
    vecs[2] = '{ 16,   0,  1,   1,  3,   16,  47, 0};
    vecs[3] = '{240,   0,  0,   0,  0,  240,  15, 0};
    vecs[4] = '{  7,  31,  1,   1,  1,    7,  38, 1};

    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_frame_out", frame_out, '0);
    chk("rst_busy",  FW'(busy), FW'(0));
    chk("rst_start", FW'(stage_start), FW'(0));
    chk("rst_err",   FW'(frame_err), FW'(0));
    chk("rst_ready", FW'(in_ready), FW'(1));

    // Directed frames.
    for (int v = 0; v < 5; v++) begin
      auto_fin  = 1'b1;
      fin_delay = vecs[v].fin_dly;
      s0 = n_starts;
      e0 = n_errs;
      for (int i = 0; i < vecs[v].pre; i++) send(DW'(200 + i), i == 0, vecs[v].gap);
      send_frame(vecs[v].base, vecs[v].sof0, vecs[v].gap);
      wait_start(100);
      $display("vec %0d: word0=%0d word31=%0d errs=%0d", v, frame_out[DW-1:0],
               frame_out[FW-1 -: DW], n_errs - e0);
      chk("vec_w0",   FW'(frame_out[DW-1:0]),   FW'(vecs[v].exp_w0));
      chk("vec_w31",  FW'(frame_out[FW-1 -: DW]), FW'(vecs[v].exp_w31));
      chk("vec_errs", FW'(n_errs - e0),          FW'(vecs[v].exp_errs));
      wait_idle(100);
      chk("vec_starts", FW'(n_starts - s0), FW'(1));
    end

    // Second frame streamed while the first is still being processed.
    fin_delay = 40;
    send_frame(0, 1'b1, 1'b0);
    send_frame(100, 1'b1, 1'b0);
    chk("b_ready_low", FW'(in_ready), FW'(0));
    chk("b_busy",      FW'(busy),     FW'(1));
    chk("a_held_w0",   FW'(frame_out[DW-1:0]),   FW'(0));
    chk("a_held_w31",  FW'(frame_out[FW-1 -: DW]), FW'(31));
    c = 0;
    while (!stage_finish && c < 100) begin tick(); c++; end
    chk("a_finish_seen", FW'(stage_finish), FW'(1));
    fin_delay = 3;
    c = 0;
    while (!stage_start && c < 20) begin tick(); c++; end
    // finish cycle -> IDLE -> XFER -> START
    chk("finish_to_start", FW'(c), FW'(3));
    chk("b_w0",  FW'(frame_out[DW-1:0]),   FW'(100));
    chk("b_w31", FW'(frame_out[FW-1 -: DW]), FW'(131));
    $display("second frame handover %0d cycles after finish", c);
    wait_idle(100);

    // Reset in the middle of a fill.
    for (int i = 0; i < 20; i++) send(DW'(150 + i), i == 0, 1'b0);
    reset = 1'b1;
    tick();
    chk("mf_ready", FW'(in_ready), FW'(0));
    chk("mf_busy",  FW'(busy), FW'(0));
    chk("mf_start", FW'(stage_start), FW'(0));
    chk("mf_err",   FW'(frame_err), FW'(0));
    chk("mf_frame", frame_out, '0);
    reset = 1'b0;
    tick();
    fin_delay = 2;
    send_frame(60, 1'b1, 1'b0);
    wait_start(100);
    chk("mf_w0",  FW'(frame_out[DW-1:0]),   FW'(60));
    chk("mf_w31", FW'(frame_out[FW-1 -: DW]), FW'(91));
    wait_idle(100);

    // Reset while the stage is busy; its late finish must be ignored.
    auto_fin = 1'b0;
    send_frame(1, 1'b1, 1'b0);
    wait_start(100);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("mb_busy",  FW'(busy), FW'(0));
    chk("mb_start", FW'(stage_start), FW'(0));
    chk("mb_frame", frame_out, '0);
    reset = 1'b0;
    s0 = n_starts;
    pulse_finish();
    repeat (4) tick();
    chk("mb_late_fin_starts", FW'(n_starts - s0), FW'(0));
    chk("mb_late_fin_busy",   FW'(busy), FW'(0));
    auto_fin  = 1'b1;
    fin_delay = 2;
    for (int i = 0; i < FFT_POINTS; i++) send(DW'(255 - i), i == 0, 1'b0);
    wait_start(100);
    chk("mb_w0",  FW'(frame_out[DW-1:0]),   FW'(255));
    chk("mb_w31", FW'(frame_out[FW-1 -: DW]), FW'(224));
    wait_idle(100);

    // Finish while idle does nothing.
    s0 = n_starts;
    pulse_finish();
    repeat (5) tick();
    chk("idle_fin_starts", FW'(n_starts - s0), FW'(0));
    chk("idle_fin_busy",   FW'(busy), FW'(0));

    // Randomized stream.
    for (int i = 0; i < 1200; i++) begin
      fin_delay = $urandom_range(0, 40);
      if ($urandom_range(0, 9) < 3) tick();
      send(DW'($urandom), $urandom_range(0, 49) == 0, 1'b0);
    end
    wait_idle(200);
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
